la_capture_controller: RTL and testbench

- Sequencing controller for the logic analyzer's sample memory (e.g. the PS/2 clock/data probes captured over the UART debug link).
- Arms on a host request, fills a programmable pre-trigger window, waits for the trigger and captures the post-trigger samples.
- Freezes the ring buffer and reports the write and oldest-sample pointers for host readout.
- Sits between the host register bank, the trigger block and the sample BRAM write port.

---
 rtl/la_pkg.sv | 18 +
 rtl/la_capture_controller.sv | 80 ++++++++
 tb/tb_la_capture_controller.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/la_pkg.sv
// la_pkg: capture state encodings shared with the host register bank
package la_pkg;

   typedef enum logic [2:0] {
      IDLE             = 3'd0,
      MOVE_TO_POSITION = 3'd1,
      IN_POSITION      = 3'd2,
      CAPTURING        = 3'd3,
      CAPTURED         = 3'd4
   } state_t;

   localparam logic [2:0] ST_IDLE             = 3'd0;
   localparam logic [2:0] ST_MOVE_TO_POSITION = 3'd1;
   localparam logic [2:0] ST_IN_POSITION      = 3'd2;
   localparam logic [2:0] ST_CAPTURING        = 3'd3;
   localparam logic [2:0] ST_CAPTURED         = 3'd4;

endpackage

// File: rtl/la_capture_controller.sv
// la_capture_controller: arms, fills the pre-trigger window, captures and freezes the sample ring buffer
module la_capture_controller
   import la_pkg::*;
#(
   parameter int SAMPLE_DEPTH = 4096,
   parameter int ADDR_W       = $clog2(SAMPLE_DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              request_start,
   input  logic              request_stop,
   input  logic [ADDR_W-1:0] trigger_loc,
   input  logic              trigger,
   output logic [2:0]        state,
   output logic [ADDR_W-1:0] write_pointer,
   output logic [ADDR_W-1:0] read_pointer,
   output logic [ADDR_W-1:0] bram_addr,
   output logic              bram_we
);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] trig_loc_q;
   logic              arm, fire, active;

   assign state     = state_q;
   assign bram_addr = write_pointer;
   assign active    = (state_q == MOVE_TO_POSITION) || (state_q == IN_POSITION) || (state_q == CAPTURING);
   // a stop cycle writes nothing so the pointers stay exactly where the abort found them
   assign bram_we   = active && !request_stop;

   // next-state logic; arm latches a new capture, fire records the trigger position
   always_comb begin
      state_d = state_q;
      arm     = 1'b0;
      fire    = 1'b0;
      case (state_q)
         IDLE, CAPTURED: begin
            if (request_start) begin
               arm     = 1'b1;
               state_d = (trigger_loc == '0) ? IN_POSITION : MOVE_TO_POSITION;
            end
         end
         MOVE_TO_POSITION: state_d = (write_pointer == trig_loc_q - ADDR_W'(1)) ? IN_POSITION : MOVE_TO_POSITION;
         IN_POSITION: begin
            if (trigger) begin
               fire    = 1'b1;
               state_d = (trig_loc_q == ADDR_W'(SAMPLE_DEPTH - 1)) ? CAPTURED : CAPTURING;
            end
         end
         CAPTURING: state_d = (write_pointer == read_pointer - ADDR_W'(1)) ? CAPTURED : CAPTURING;
         default: state_d = IDLE;
      endcase
      if (request_stop) begin
         state_d = IDLE;
         arm     = 1'b0;
         fire    = 1'b0;
      end
   end

   // state and pointer registers; the write pointer wraps by natural overflow
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         write_pointer <= '0;
         read_pointer  <= '0;
         trig_loc_q    <= '0;
      end else begin
         state_q <= state_d;
         if (arm) begin
            write_pointer <= '0;
            read_pointer  <= '0;
            trig_loc_q    <= trigger_loc;
         end else if (bram_we) begin
            write_pointer <= write_pointer + ADDR_W'(1);
         end
         if (fire) read_pointer <= write_pointer - trig_loc_q;
      end
   end

endmodule

// File: tb/tb_la_capture_controller.sv
// tb_la_capture_controller: scoreboard bench with a capture-level reference model
module tb_la_capture_controller;

   localparam int D  = 16;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          request_start = 1'b0;
   logic          request_stop = 1'b0;
   logic          trigger = 1'b0;
   logic [AW-1:0] trigger_loc = '0;
   logic [2:0]    state;
   logic [AW-1:0] write_pointer, read_pointer, bram_addr;
   logic          bram_we;

   int n_checks = 0;
   int n_fail   = 0;
   int addr_q[$];
   int rp_q[$];
   int wp_q[$];
   logic [2:0] prev_state = 3'd0;

   la_capture_controller #(.SAMPLE_DEPTH(D)) dut (
      .clk(clk), .rst(rst), .request_start(request_start), .request_stop(request_stop),
      .trigger_loc(trigger_loc), .trigger(trigger), .state(state),
      .write_pointer(write_pointer), .read_pointer(read_pointer),
      .bram_addr(bram_addr), .bram_we(bram_we)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // monitor: every BRAM write and every entry into CAPTURED is checked against the scoreboard
   always @(negedge clk) begin
      if (!rst) begin
         if (bram_we) begin
            if (addr_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL spurious_write: got write at address %0d, expected no write", bram_addr);
            end else check("bram_addr", int'(bram_addr), addr_q.pop_front());
         end
         if (state == 3'd4 && prev_state != 3'd4) begin
            if (rp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL spurious_capture: got CAPTURED, expected no capture");
            end else begin
               check("read_pointer", int'(read_pointer), rp_q.pop_front());
               check("write_pointer", int'(write_pointer), wp_q.pop_front());
            end
         end
      end
      prev_state <= rst ? 3'd0 : state;
   end

   // reference model: L prefill writes, the first trigger at write index ti >= L is the
   // trigger sample, then D-1-L more samples complete a full buffer
   task automatic expect_capture(input int l, input int ti, output int wp_exp);
      int n;
      n = ti + D - l;
      for (int i = 0; i < n; i++) addr_q.push_back(i % D);
      rp_q.push_back(((ti % D) - l + D) % D);
      wp_exp = n % D;
      wp_q.push_back(wp_exp);
   endtask

   task automatic run_capture(input int l, input int ti, input bit noise);
      int wp_exp;
      expect_capture(l, ti, wp_exp);
      request_start = 1'b1;
      trigger_loc   = AW'(l);
      @(posedge clk); #1;
      request_start = 1'b0;
      for (int i = 0; i <= ti; i++) begin
         trigger_loc   = AW'($urandom);
         trigger       = (i == ti) || (noise && i < l && ($urandom % 2 == 1));
         request_start = noise && ($urandom % 4 == 0);
         @(posedge clk); #1;
      end
      request_start = 1'b0;
      for (int c = 0; c < 2 * D && state != 3'd4; c++) begin
         trigger = noise && ($urandom % 2 == 1);
         @(posedge clk); #1;
      end
      trigger = 1'b0;
      check("captured_state", int'(state), 4);
      repeat (3) @(posedge clk);
      #1;
      check("frozen_wp", int'(write_pointer), wp_exp);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: got no end of test, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("reset_state", int'(state), 0);
      check("reset_we", int'(bram_we), 0);
      check("reset_wp", int'(write_pointer), 0);
      check("reset_rp", int'(read_pointer), 0);

      run_capture(4, 9, 1'b0);
      run_capture(0, 0, 1'b0);
      run_capture(15, 20, 1'b1);
      run_capture(2, 3 * D + 7, 1'b0);

      // abort together with a trigger while capturing
      request_start = 1'b1;
      trigger_loc   = AW'(3);
      @(posedge clk); #1;
      request_start = 1'b0;
      for (int i = 0; i < 9; i++) addr_q.push_back(i);
      for (int i = 0; i < 9; i++) begin
         trigger = (i == 6);
         @(posedge clk); #1;
      end
      check("capturing_state", int'(state), 3);
      trigger      = 1'b1;
      request_stop = 1'b1;
      @(posedge clk); #1;
      trigger      = 1'b0;
      request_stop = 1'b0;
      check("stop_state", int'(state), 0);
      check("stop_we", int'(bram_we), 0);
      check("stop_wp", int'(write_pointer), 9);
      check("stop_rp", int'(read_pointer), 3);

      run_capture(6, 11, 1'b1);

      // reset in the middle of a capture
      request_start = 1'b1;
      trigger_loc   = AW'(5);
      @(posedge clk); #1;
      request_start = 1'b0;
      for (int i = 0; i < 7; i++) addr_q.push_back(i);
      repeat (7) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      addr_q.delete();
      check("midrst_state", int'(state), 0);
      check("midrst_we", int'(bram_we), 0);
      check("midrst_wp", int'(write_pointer), 0);
      check("midrst_rp", int'(read_pointer), 0);

      for (int k = 0; k < 8; k++) begin
         int l;
         l = int'($urandom_range(0, D - 1));
         run_capture(l, l + int'($urandom_range(0, 40)), 1'b1);
      end

      check("addr_q_drained", addr_q.size(), 0);
      check("cap_q_drained", rp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
